// File: rtl/fifo_1r1w_pkg.sv
// Shared sizing helpers for fifo_1r1w: pointer/count widths and a depth legality check.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_1r1w_if.sv
// Ready/valid bundle for fifo_1r1w; slave is the FIFO side, master the surrounding stages.
interface fifo_1r1w_if
  import fifo_pkg::*;
#(
  parameter int width_p = 8,
  parameter int depth_p = 16
) ();

  logic                             valid_i;
  logic [width_p-1:0]               data_i;
  logic                             ready_o;
  logic                             valid_o;
  logic [width_p-1:0]               data_o;
  logic                             ready_i;
  logic [cnt_width(depth_p)-1:0]    count_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, count_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, count_o
  );

endinterface

// File: rtl/fifo_1r1w_counter_roll.sv
// Up/down counter that rolls over between 0 and max_val_p in both directions.
module counter_roll #(
  parameter int width_p     = 4,
  parameter int max_val_p   = 15,
  parameter int reset_val_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);
  localparam logic [width_p-1:0] rst_lp = width_p'(reset_val_p);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i) begin
      count_d = (count_q == max_lp) ? '0 : count_q + width_p'(1);
    end else if (down_i && !up_i) begin
      count_d = (count_q == '0) ? max_lp : count_q - width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= rst_lp;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fifo_1r1w.sv
// First-word-fall-through ready/valid FIFO with separate occupancy tracking.
// Define FIFO_BYPASS_EN to let a word pass straight through when empty and downstream is ready.
module fifo_1r1w
  import fifo_pkg::*;
#(
  parameter int width_p = 8,
  parameter int depth_p = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  fifo_1r1w_if.slave  bus
);

  localparam int ptr_w_lp = ptr_width(depth_p);
  localparam int cnt_w_lp = cnt_width(depth_p);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(depth_p);

  if (!is_pow2(depth_p)) begin : g_depth_check
    $error("fifo_1r1w: depth_p must be a power of two and at least 2");
  end

  logic [width_p-1:0]  mem_q [depth_p];
  logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                push, pop, stored_valid, bypass;

  assign stored_valid = (count_q != '0);
  assign bus.ready_o  = !reset_i && (count_q != full_lp);

`ifdef FIFO_BYPASS_EN
  // An empty FIFO with a ready consumer hands the incoming word over directly.
  assign bypass      = !reset_i && !stored_valid && bus.valid_i && bus.ready_i;
  assign bus.valid_o = stored_valid || bypass;
  assign bus.data_o  = bypass ? bus.data_i : mem_q[rd_ptr];
`else
  assign bypass      = 1'b0;
  assign bus.valid_o = stored_valid;
  assign bus.data_o  = mem_q[rd_ptr];
`endif

  assign push        = bus.valid_i && bus.ready_o && !bypass;
  assign pop         = stored_valid && bus.ready_i;
  assign bus.count_o = count_q;

  counter_roll #(
    .width_p    (ptr_w_lp),
    .max_val_p  (depth_p - 1),
    .reset_val_p(0)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (push),
    .down_i (1'b0),
    .count_o(wr_ptr)
  );

  counter_roll #(
    .width_p    (ptr_w_lp),
    .max_val_p  (depth_p - 1),
    .reset_val_p(0)
  ) u_rd_ptr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (pop),
    .down_i (1'b0),
    .count_o(rd_ptr)
  );

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr] <= bus.data_i;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: tb/tb_fifo_1r1w.sv
// Directed plus randomized bench for fifo_1r1w against a queue-based reference model.
module tb_fifo_1r1w;

  localparam int W = 8;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_1r1w_if #(.width_p(W), .depth_p(D)) bus ();

  fifo_1r1w #(.width_p(W), .depth_p(D)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  logic [W-1:0] q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, then advance the model at posedge.
  task automatic step(input logic r_rst, input logic v, input logic [W-1:0] d,
                      input logic r, output logic acc);
    logic byp, exp_valid, push_m, pop_m;
    @(negedge clk);
    rst         = r_rst;
    bus.valid_i = v;
    bus.data_i  = d;
    bus.ready_i = r;
    #1;
    byp = 1'b0;
`ifdef FIFO_BYPASS_EN
    byp = !r_rst && (q.size() == 0) && v && r;
`endif
    exp_valid = (q.size() != 0) || byp;
    chk("ready_o", 32'(bus.ready_o), 32'(!r_rst && (q.size() < D)));
    chk("valid_o", 32'(bus.valid_o), 32'(exp_valid));
    chk("count_o", 32'(bus.count_o), 32'(q.size()));
    if (exp_valid) chk("data_o", 32'(bus.data_o), 32'(byp ? d : q[0]));
    push_m = !r_rst && v && (q.size() < D) && !byp;
    pop_m  = !r_rst && (q.size() != 0) && r;
    acc    = push_m || byp;
    @(posedge clk);
    if (r_rst) q.delete();
    else begin
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(d);
    end
  endtask

  initial begin
    logic acc;
    logic pend;
    logic [W-1:0] pd;
    logic v, r;
    logic [W-1:0] d;

    rst = 1'b1; bus.valid_i = 1'b0; bus.data_i = '0; bus.ready_i = 1'b0;
    @(posedge clk);

    // reset held, then idle
    step(1'b1, 1'b0, 8'h00, 1'b0, acc);
    step(1'b1, 1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, acc);

    // fill to full, then an extra word must be refused
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, W'(i), 1'b0, acc);
    step(1'b0, 1'b1, 8'hAA, 1'b0, acc);
    chk("full_refuse", 32'(acc), 32'(0));

    // drain in order
    for (int i = 0; i < D; i++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, acc);

    // offset pointers, then stream to force wrap
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, W'(8'h80 + i), 1'b0, acc);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, W'(i), 1'b1, acc);
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // full with simultaneous pop: pop only, then push accepted
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, W'(8'h40 + i), 1'b0, acc);
    step(1'b0, 1'b1, 8'h77, 1'b1, acc);
    chk("full_pop_no_push", 32'(acc), 32'(0));
    step(1'b0, 1'b1, 8'h77, 1'b0, acc);
    chk("push_after_pop", 32'(acc), 32'(1));
    for (int i = 0; i < D + 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // reset mid-stream at count 5, then single-word latency / bypass
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'(8'h20 + i), 1'b0, acc);
    step(1'b1, 1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 1'b1, 8'h5A, 1'b1, acc);
    step(1'b0, 1'b0, 8'h00, 1'b1, acc);
    step(1'b0, 1'b0, 8'h00, 1'b1, acc);

    // randomized traffic honouring the hold-while-stalled rule
    pend = 1'b0;
    pd   = '0;
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 64) == 0 && !pend) begin
        step(1'b1, 1'b0, 8'h00, 1'b0, acc);
      end else begin
        v = pend ? 1'b1 : (($urandom % 4) != 0);
        d = pend ? pd : W'($urandom);
        r = (($urandom % 3) != 0);
        step(1'b0, v, d, r, acc);
        pend = v && !acc;
        pd   = d;
      end
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_1r1w.md
Name: fifo_1r1w

Overview:
Elastic ready/valid FIFO between pixel-stream stages, e.g. camera capture to the filter/window stages. Storage is a register array with first-word-fall-through: the head entry is always visible on data_o. Read and write pointers are two counter_roll instances that increment only and wrap from depth_p-1 to 0. Occupancy is tracked separately, which removes full/empty pointer ambiguity.

Parameters:
width_p, 8, data word width in bits.
depth_p, 16, number of entries; power of two, minimum 2.

Ports:
clk_i  input  1  clock.
reset_i  input  1  synchronous, active-high reset.
valid_i  input  1  upstream word valid.
data_i  input  width_p  upstream word.
ready_o  output  1  FIFO can accept a word.
valid_o  output  1  head word valid.
data_o  output  width_p  head word, FWFT.
ready_i  input  1  downstream accepts head word.
count_o  output  $clog2(depth_p+1)  current occupancy.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count_o = 0.
  - valid_o = 0, ready_o = 0 while reset_i is high; ready_o = 1 on the first cycle after reset.
  - Storage array is not reset. data_o is don't-care while valid_o = 0.
- Handshake events:
  - Write (push) = valid_i & ready_o.
  - Read (pop) = valid_o & ready_i.
- Flag definitions:
  - ready_o = !reset_i & (count_o != depth_p).
  - valid_o = (count_o != 0).
  - Both are pure functions of registered state; no combinational path from valid_i or ready_i (except under the optional feature).
- Push: mem[wr_ptr] <= data_i; wr_ptr advances via counter_roll up_i; down_i tied 0.
- Pop: rd_ptr advances the same way. data_o = mem[rd_ptr], combinational from the array.
- Pointer width is $clog2(depth_p). The roll from depth_p-1 to 0 is the counter's natural wrap.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: hold.
- Full (count = depth_p): ready_o = 0, so no push. A pop in that cycle still occurs; ready_o = 1 next cycle. There is no same-cycle write-through when full.
- Empty (count = 0): valid_o = 0, so no pop. A push sets valid_o = 1 on the next cycle; minimum latency is 1 cycle.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Protocol assumptions:
  - Upstream holds data_i stable while valid_i & !ready_o.
  - The FIFO holds data_o stable while valid_o & !ready_i.
- Reset mid-stream: all contents are discarded; the next cycle is empty.

Optional Feature:
FIFO_BYPASS_EN:
- Defined: when count_o = 0 and valid_i & ready_i, the word passes through in the same cycle.
  - valid_o = 1 and data_o = data_i combinationally.
  - No push, count and pointers unchanged; ready_o stays 1.
  - This adds a combinational valid_i/data_i to valid_o/data_o path.
  - If ready_i = 0 while empty, a normal push occurs.
- Undefined: no bypass; empty-to-output latency is always 1 cycle.

Decomposition:
- Shared package fifo_pkg holds:
  - ptr_width function: depth <= 1 ? 1 : $clog2(depth).
  - cnt_width function: $clog2(depth+1).
  - A depth power-of-two check used in an elaboration-time assertion.
- Sub-module: counter_roll, instantiated twice (wr_ptr, rd_ptr) with max_val_p = depth_p-1 and reset_val_p = 0.
- Storage stays inline; no separate RAM module.

Test Plan:
- Reset then idle: reset_i high 2 cycles → valid_o = 0, ready_o = 0 during reset; ready_o = 1 and count_o = 0 after.
- Fill to full, depth 16: push 0x00..0x0F with ready_i = 0 → count_o = 16, ready_o = 0; a 17th valid_i (0xAA) is not accepted.
- Drain order: from full, ready_i = 1 → data_o sequence 0x00..0x0F, one per cycle; valid_o = 0 after the 16th pop, count_o = 0.
- Wrap and simultaneous push/pop: push 10, pop 10, then stream 40 words (0x00..0x27) with valid_i = ready_i = 1 → pointers wrap; count_o stays 1 in steady state; output order intact with no gaps after the first cycle.
- Full with pop: at count = 16, valid_i = 1 and ready_i = 1 → pop only, count_o = 15; next cycle ready_o = 1 and the push is accepted.
- Reset mid-stream plus bypass check:
  - Reset at count = 5 → next cycle count_o = 0, valid_o = 0.
  - With FIFO_BYPASS_EN defined, empty, push 0x5A with ready_i = 1 → valid_o = 1 and data_o = 0x5A in the same cycle, count_o stays 0.
  - Without the macro, valid_o rises one cycle later.
